// File: rtl/bcd_press_counter_pkg.sv
// Shared types and constants for the BCD press counter slice.
package bcd_press_counter_pkg;

  localparam int unsigned DIGIT_W  = 4;
  localparam logic [3:0]  BCD_ZERO = 4'd0;
  localparam logic [3:0]  BCD_NINE = 4'd9;

  // One-bit FSM encoding: RUN=0, FROZEN=1.
  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_FROZEN = 1'b1
  } state_e;

  // Next value of a single BCD digit for one increment or decrement step.
  // Out-of-range codes are folded back into 0..9 so a digit can never stick at A..F.
  function automatic logic [3:0] bcd_step(input logic [3:0] d,
                                          input logic       inc,
                                          input logic       dec);
    logic [3:0] r;
    r = d;
    if (inc) begin
      r = (d >= BCD_NINE) ? BCD_ZERO : 4'(d + 4'd1);
    end else if (dec) begin
      r = ((d == BCD_ZERO) || (d > BCD_NINE)) ? BCD_NINE : 4'(d - 4'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_press_counter_if.sv
// Press-pulse inputs and display-side outputs of the BCD press counter.
interface bcd_press_counter_if
  import bcd_press_counter_pkg::*;
#(
  parameter int unsigned DIGITS = 4
);

  localparam int unsigned CW = DIGIT_W * DIGITS;

  logic          up_pulse;
  logic          down_pulse;
  logic          clr_pulse;
  logic          frz_pulse;
  logic [CW-1:0] count;
  logic          frozen;
  logic          wrap_evt;
  logic          at_zero;
  logic          at_max;

  // Debounce/producer side.
  modport master (
    output up_pulse, down_pulse, clr_pulse, frz_pulse,
    input  count, frozen, wrap_evt, at_zero, at_max
  );

  // Counter side.
  modport slave (
    input  up_pulse, down_pulse, clr_pulse, frz_pulse,
    output count, frozen, wrap_evt, at_zero, at_max
  );

endinterface

// File: rtl/bcd_press_counter_bcd_digit.sv
// One BCD digit: combinational next-value logic plus 9/0 flags for the chain.
module bcd_digit
  import bcd_press_counter_pkg::*;
(
  input  logic [3:0] cur,
  input  logic       inc,
  input  logic       dec,
  input  logic       en,
  output logic [3:0] nxt,
  output logic       is9,
  output logic       is0
);

  assign is9 = (cur == BCD_NINE);
  assign is0 = (cur == BCD_ZERO);

  // Step only when every lower digit is rolling over (en from the chain).
  always_comb begin
    nxt = cur;
    if (en) begin
      nxt = bcd_step(cur, inc, dec);
    end
  end

endmodule

// File: rtl/bcd_press_counter.sv
// Counts debounced up/down/clear/freeze pulses into a packed BCD value.
module bcd_press_counter
  import bcd_press_counter_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter bit          WRAP   = 1'b1
)(
  input  logic                Clk190,
  input  logic                Reset,
  bcd_press_counter_if.slave  bus
);

  localparam int unsigned CW = DIGIT_W * DIGITS;

  state_e             state_q;
  state_e             state_n;
  logic [CW-1:0]      count_q;
  logic [CW-1:0]      count_n;
  logic [CW-1:0]      step_cnt;
  logic               wrap_q;
  logic               wrap_n;
  logic               op_inc;
  logic               op_dec;
  logic               op_clr;
  logic [DIGITS-1:0]  is9;
  logic [DIGITS-1:0]  is0;
  logic [DIGITS-1:0]  inc_en;
  logic [DIGITS-1:0]  dec_en;
  logic               at_max_c;
  logic               at_zero_c;

  assign at_max_c  = &is9;
  assign at_zero_c = &is0;

  // Digit array with carry/borrow enables formed as the AND of all lower flags.
  for (genvar k = 0; k < int'(DIGITS); k++) begin : g_digit
    if (k == 0) begin : g_lsd
      assign inc_en[k] = 1'b1;
      assign dec_en[k] = 1'b1;
    end else begin : g_upper
      assign inc_en[k] = &is9[k-1:0];
      assign dec_en[k] = &is0[k-1:0];
    end

    bcd_digit u_digit (
      .cur (count_q[DIGIT_W*k +: DIGIT_W]),
      .inc (op_inc),
      .dec (op_dec),
      .en  (op_inc ? inc_en[k] : dec_en[k]),
      .nxt (step_cnt[DIGIT_W*k +: DIGIT_W]),
      .is9 (is9[k]),
      .is0 (is0[k])
    );
  end

  // Priority decode: clear, then freeze toggle, then RUN-only up/down.
  always_comb begin
    state_n = state_q;
    op_inc  = 1'b0;
    op_dec  = 1'b0;
    op_clr  = 1'b0;
    wrap_n  = 1'b0;
    if (bus.clr_pulse) begin
      op_clr = 1'b1;
    end else if (bus.frz_pulse) begin
      state_n = (state_q == ST_RUN) ? ST_FROZEN : ST_RUN;
    end else if ((state_q == ST_RUN) && (bus.up_pulse ^ bus.down_pulse)) begin
      if (bus.up_pulse) begin
        // All-nines naturally rolls to zero through the carry chain.
        wrap_n = at_max_c;
        op_inc = at_max_c ? WRAP : 1'b1;
      end else begin
        // All-zeros naturally rolls to all-nines through the borrow chain.
        wrap_n = at_zero_c;
        op_dec = at_zero_c ? WRAP : 1'b1;
      end
    end
  end

  // Next count: clear wins, otherwise take the stepped digits when stepping.
  always_comb begin
    count_n = count_q;
    if (op_clr) begin
      count_n = '0;
    end else if (op_inc || op_dec) begin
      count_n = step_cnt;
    end
  end

  // State, count and boundary-event registers.
  always_ff @(posedge Clk190 or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_RUN;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      count_q <= count_n;
      wrap_q  <= wrap_n;
    end
  end

  assign bus.count    = count_q;
  assign bus.frozen   = (state_q == ST_FROZEN);
  assign bus.wrap_evt = wrap_q;
  assign bus.at_zero  = at_zero_c;
  assign bus.at_max   = at_max_c;

endmodule

// File: tb/tb_bcd_press_counter.sv
// Self-checking bench: a WRAP=1 and a WRAP=0 counter driven in lockstep
// against an integer-valued reference model.
module tb_bcd_press_counter;

  localparam int MAXV = 9999;

  logic Clk190 = 1'b0;
  logic Reset;
  bit   chk_en = 1'b0;
  int   total  = 0;
  int   bad    = 0;

  // Reference model: decimal value per counter, shared freeze flag.
  int mv   [2];
  bit mevt [2];
  bit mfrz;

  bcd_press_counter_if #(.DIGITS(4)) bw ();
  bcd_press_counter_if #(.DIGITS(4)) bs ();

  bcd_press_counter #(.DIGITS(4), .WRAP(1'b1)) u_wrap (
    .Clk190 (Clk190),
    .Reset  (Reset),
    .bus    (bw)
  );

  bcd_press_counter #(.DIGITS(4), .WRAP(1'b0)) u_sat (
    .Clk190 (Clk190),
    .Reset  (Reset),
    .bus    (bs)
  );

  always #5 Clk190 = ~Clk190;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          x;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mv[i]   = 0;
      mevt[i] = 1'b0;
    end
    mfrz = 1'b0;
  endtask

  // Index 0 wraps, index 1 saturates.
  task automatic model_step(input bit u, input bit d, input bit c, input bit f);
    for (int i = 0; i < 2; i++) begin
      mevt[i] = 1'b0;
      if (c) begin
        mv[i] = 0;
      end else if (!f && !mfrz && (u != d)) begin
        if (u) begin
          if (mv[i] == MAXV) begin
            mevt[i] = 1'b1;
            if (i == 0) mv[i] = 0;
          end else begin
            mv[i] = mv[i] + 1;
          end
        end else begin
          if (mv[i] == 0) begin
            mevt[i] = 1'b1;
            if (i == 0) mv[i] = MAXV;
          end else begin
            mv[i] = mv[i] - 1;
          end
        end
      end
    end
    if (!c && f) mfrz = ~mfrz;
  endtask

  task automatic drive(input bit u, input bit d, input bit c, input bit f);
    bw.up_pulse = u; bw.down_pulse = d; bw.clr_pulse = c; bw.frz_pulse = f;
    bs.up_pulse = u; bs.down_pulse = d; bs.clr_pulse = c; bs.frz_pulse = f;
  endtask

  // One clock with the given pulses; returns just after the following falling edge.
  task automatic pulse(input bit u, input bit d, input bit c, input bit f);
    drive(u, d, c, f);
    @(posedge Clk190);
    model_step(u, d, c, f);
    @(negedge Clk190);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cmp(input string tag, input int i, input logic [15:0] cnt,
                     input logic frz, input logic evt, input logic az, input logic am);
    logic [3:0] dg;
    check({tag, "_count"},    32'(cnt), 32'(to_bcd(mv[i])));
    check({tag, "_frozen"},   32'(frz),  32'(mfrz));
    check({tag, "_wrap_evt"}, 32'(evt),  32'(mevt[i]));
    check({tag, "_at_zero"},  32'(az),   32'(mv[i] == 0));
    check({tag, "_at_max"},   32'(am),   32'(mv[i] == MAXV));
    for (int k = 0; k < 4; k++) begin
      dg = cnt[4*k +: 4];
      check({tag, "_digit_le9"}, 32'(dg <= 4'd9), 32'd1);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge Clk190) begin
    if (chk_en && !Reset) begin
      cmp("wrap", 0, bw.count, bw.frozen, bw.wrap_evt, bw.at_zero, bw.at_max);
      cmp("sat",  1, bs.count, bs.frozen, bs.wrap_evt, bs.at_zero, bs.at_max);
    end
  end

  // Reset pulsed between clock edges; outputs must clear before any edge.
  task automatic async_reset(input bit lit);
    #1;
    Reset = 1'b1;
    model_reset();
    #1;
    if (lit) begin
      check("async_wrap_count",  32'(bw.count),  32'h0);
      check("async_wrap_frozen", 32'(bw.frozen), 32'h0);
      check("async_sat_count",   32'(bs.count),  32'h0);
      check("async_sat_frozen",  32'(bs.frozen), 32'h0);
    end
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    bit u, d, c, f;
    int r;
    Reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #22;
    Reset = 1'b0;
    @(negedge Clk190);
    #1;
    chk_en = 1'b1;

    // Reset state
    check("rst_count",  32'(bw.count),    32'h0);
    check("rst_frozen", 32'(bw.frozen),   32'h0);
    check("rst_evt",    32'(bw.wrap_evt), 32'h0);
    check("rst_zero",   32'(bw.at_zero),  32'h1);

    // Twelve presses
    repeat (12) pulse(1, 0, 0, 0);
    check("t1_count", 32'(bw.count),   32'h0012);
    check("t1_zero",  32'(bw.at_zero), 32'h0);

    // Carry and borrow across a digit boundary
    pulse(0, 0, 1, 0);
    repeat (99) pulse(1, 0, 0, 0);
    check("t2_0099", 32'(bw.count), 32'h0099);
    pulse(1, 0, 0, 0);
    check("t2_0100", 32'(bw.count), 32'h0100);
    pulse(0, 1, 0, 0);
    check("t2_back", 32'(bw.count), 32'h0099);

    // Top boundary: wrap vs saturate
    pulse(0, 0, 1, 0);
    repeat (MAXV) pulse(1, 0, 0, 0);
    check("t3_w_9999", 32'(bw.count),  32'h9999);
    check("t3_w_max",  32'(bw.at_max), 32'h1);
    check("t3_s_9999", 32'(bs.count),  32'h9999);
    pulse(1, 0, 0, 0);
    check("t3_w_wrap0",  32'(bw.count),    32'h0000);
    check("t3_w_evt",    32'(bw.wrap_evt), 32'h1);
    check("t4_s_hold",   32'(bs.count),    32'h9999);
    check("t4_s_evt",    32'(bs.wrap_evt), 32'h1);
    pulse(0, 0, 0, 0);
    check("t3_w_evt_1cy", 32'(bw.wrap_evt), 32'h0);
    check("t4_s_evt_1cy", 32'(bs.wrap_evt), 32'h0);

    // Bottom boundary: wrap vs saturate
    pulse(0, 0, 1, 0);
    pulse(0, 1, 0, 0);
    check("t3_w_wrap9", 32'(bw.count),    32'h9999);
    check("t3_w_evt2",  32'(bw.wrap_evt), 32'h1);
    check("t4_s_hold0", 32'(bs.count),    32'h0000);
    check("t4_s_evt2",  32'(bs.wrap_evt), 32'h1);

    // Freeze and priority
    pulse(0, 0, 1, 0);
    repeat (3) pulse(1, 0, 0, 0);
    pulse(0, 0, 0, 1);
    check("t5_frozen", 32'(bw.frozen), 32'h1);
    repeat (5) pulse(1, 0, 0, 0);
    check("t5_frz_hold", 32'(bw.count), 32'h0003);
    pulse(0, 0, 1, 0);
    check("t5_clr_cnt", 32'(bw.count),  32'h0000);
    check("t5_clr_frz", 32'(bw.frozen), 32'h1);
    pulse(1, 0, 0, 1);
    check("t5_unfrz",     32'(bw.frozen), 32'h0);
    check("t5_frz_up_ig", 32'(bw.count),  32'h0000);
    pulse(1, 0, 0, 0);
    pulse(1, 1, 0, 0);
    check("t5_updown", 32'(bw.count),    32'h0001);
    check("t5_ud_evt", 32'(bw.wrap_evt), 32'h0);

    // Asynchronous reset while frozen at 0457
    pulse(0, 0, 1, 0);
    repeat (457) pulse(1, 0, 0, 0);
    pulse(0, 0, 0, 1);
    check("t6_pre_cnt", 32'(bw.count),  32'h0457);
    check("t6_pre_frz", 32'(bw.frozen), 32'h1);
    async_reset(1'b1);

    // Random soak
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      u = (r < 45);
      d = (r >= 40) && (r < 85);
      c = (r >= 98);
      f = (r >= 90) && (r < 93);
      pulse(u, d, c, f);
      if ($urandom_range(0, 399) == 0) async_reset(1'b0);
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
